mine_game_ctrl: RTL and testbench

- Moore FSM that sequences the minesweeper datapath through one game: mine placement, per-move load, decode, alu and display.
- Accepts user moves through a valid/ready handshake and rejects illegal moves before they reach the datapath.
- Waits on each datapath done flag, with a watchdog per stage, and reports game result and move count to the top level.

---
 rtl/mine_game_ctrl_if.sv | 37 +++
 rtl/mine_game_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mine_game_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mine_game_ctrl_if.sv
// mine_game_ctrl_if
// Groups the user move handshake and the datapath strobe/done bus of the
// minesweeper game controller.
//   move_valid/move_data/move_ready/move_err : user move handshake
//   start/load/decode/alu/display/data       : controller -> datapath strobes
//   place_done/decode_done/alu_done/display_done/gameover/win : datapath -> controller
// Modports: slave = the controller, master = the user/datapath environment.
interface mine_game_ctrl_if;
  logic       move_valid;
  logic [4:0] move_data;
  logic       move_ready;
  logic       move_err;
  logic       place_done;
  logic       decode_done;
  logic       alu_done;
  logic       display_done;
  logic       gameover;
  logic       win;
  logic       start;
  logic       load;
  logic       decode;
  logic       alu;
  logic       display;
  logic [4:0] data;

  modport slave (
    input  move_valid, move_data, place_done, decode_done, alu_done,
           display_done, gameover, win,
    output move_ready, move_err, start, load, decode, alu, display, data
  );

  modport master (
    output move_valid, move_data, place_done, decode_done, alu_done,
           display_done, gameover, win,
    input  move_ready, move_err, start, load, decode, alu, display, data
  );
endinterface

// File: rtl/mine_game_ctrl.sv
// mine_game_ctrl
// Moore FSM sequencing the minesweeper datapath through one game: mine
// placement, then per legal move load -> decode -> alu -> display, until the
// datapath reports game over. Illegal moves (out of range or already played)
// are rejected with a one-cycle move_err pulse. Each done-wait state has a
// watchdog; expiry lands in ERR.
// Ports:
//   clka      : clock, rising edge
//   restart   : asynchronous active-high reset
//   new_game  : start a new game from IDLE, OVER or ERR
//   mif       : move handshake + datapath bus (slave side)
//   moves     : legal moves accepted this game, saturating at 31
//   game_over : high in OVER
//   game_won  : latched win result, valid in OVER
//   err       : high in ERR (watchdog expiry)
module mine_game_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int NCELLS  = 25
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             new_game,
  mine_game_ctrl_if.slave  mif,
  output logic [4:0]       moves,
  output logic             game_over,
  output logic             game_won,
  output logic             err
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] PLACE     = 4'd1;
  localparam logic [3:0] WAIT_MOVE = 4'd2;
  localparam logic [3:0] LOAD      = 4'd3;
  localparam logic [3:0] DECODE    = 4'd4;
  localparam logic [3:0] ALU       = 4'd5;
  localparam logic [3:0] DISPLAY   = 4'd6;
  localparam logic [3:0] OVER      = 4'd7;
  localparam logic [3:0] ERR       = 4'd8;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [3:0]        state_q, state_d;
  logic [NCELLS-1:0] played_q, played_d;
  logic [4:0]        data_q, data_d;
  logic [4:0]        moves_q, moves_d;
  logic [7:0]        wd_q, wd_d;
  logic              won_q, won_d;
  logic              go_cap_q, go_cap_d;
  logic              win_cap_q, win_cap_d;
  logic              merr_q, merr_d;

  logic [NCELLS-1:0] cell_onehot_s;
  logic              move_legal_s;
  logic              wd_expired_s;
  logic              waiting_s;

  // Decode the offered cell index; an index >= NCELLS matches no bit and so is illegal.
  always_comb begin
    cell_onehot_s = {NCELLS{1'b0}};
    for (int i = 0; i < NCELLS; i++) begin
      if (mif.move_data == 5'(i)) begin
        cell_onehot_s[i] = 1'b1;
      end else begin
        cell_onehot_s[i] = 1'b0;
      end
    end
    move_legal_s = (|cell_onehot_s) && ((cell_onehot_s & played_q) == {NCELLS{1'b0}});
  end

  // Next-state and datapath-register logic of the game FSM.
  always_comb begin
    state_d      = state_q;
    played_d     = played_q;
    data_d       = data_q;
    moves_d      = moves_q;
    won_d        = won_q;
    go_cap_d     = go_cap_q;
    win_cap_d    = win_cap_q;
    merr_d       = 1'b0;
    wd_expired_s = (wd_q == WD_LAST);
    case (state_q)
      // Entry into PLACE clears per-game state so it already reads zero during placement.
      IDLE, OVER, ERR: begin
        if (new_game) begin
          state_d  = PLACE;
          played_d = {NCELLS{1'b0}};
          moves_d  = 5'd0;
          won_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      PLACE: begin
        played_d = {NCELLS{1'b0}};
        moves_d  = 5'd0;
        won_d    = 1'b0;
        if (mif.place_done) begin
          state_d = WAIT_MOVE;
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = PLACE;
        end
      end
      // new_game is deliberately not looked at here.
      WAIT_MOVE: begin
        if (mif.move_valid && move_legal_s) begin
          state_d  = LOAD;
          data_d   = mif.move_data;
          played_d = played_q | cell_onehot_s;
          moves_d  = (moves_q == 5'd31) ? moves_q : moves_q + 5'd1;
        end else if (mif.move_valid) begin
          merr_d = 1'b1;
        end else begin
          state_d = WAIT_MOVE;
        end
      end
      // The datapath gives no load-done, so LOAD always lasts one cycle.
      LOAD: begin
        state_d = DECODE;
      end
      DECODE: begin
        if (mif.decode_done) begin
          state_d = ALU;
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = DECODE;
        end
      end
      ALU: begin
        if (mif.alu_done) begin
          state_d   = DISPLAY;
          go_cap_d  = mif.gameover;
          win_cap_d = mif.win;
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = ALU;
        end
      end
      DISPLAY: begin
        if (mif.display_done && go_cap_q) begin
          state_d = OVER;
          won_d   = win_cap_q;
        end else if (mif.display_done) begin
          state_d = WAIT_MOVE;
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = DISPLAY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Watchdog: restarts on every state change and counts only while a done is awaited.
  always_comb begin
    waiting_s = (state_q == PLACE) || (state_q == DECODE) ||
                (state_q == ALU)   || (state_q == DISPLAY);
    if (state_d != state_q) begin
      wd_d = 8'd0;
    end else if (waiting_s) begin
      wd_d = wd_q + 8'd1;
    end else begin
      wd_d = 8'd0;
    end
  end

  // State and datapath registers with asynchronous restart.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q   <= IDLE;
      played_q  <= {NCELLS{1'b0}};
      data_q    <= 5'd0;
      moves_q   <= 5'd0;
      wd_q      <= 8'd0;
      won_q     <= 1'b0;
      go_cap_q  <= 1'b0;
      win_cap_q <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      played_q  <= played_d;
      data_q    <= data_d;
      moves_q   <= moves_d;
      wd_q      <= wd_d;
      won_q     <= won_d;
      go_cap_q  <= go_cap_d;
      win_cap_q <= win_cap_d;
      merr_q    <= merr_d;
    end
  end

  // Outputs are either flops or decodes of the state flop.
  assign mif.start      = (state_q == PLACE);
  assign mif.load       = (state_q == LOAD);
  assign mif.decode     = (state_q == DECODE);
  assign mif.alu        = (state_q == ALU);
  assign mif.display    = (state_q == DISPLAY);
  assign mif.move_ready = (state_q == WAIT_MOVE);
  assign mif.move_err   = merr_q;
  assign mif.data       = data_q;
  assign moves          = moves_q;
  assign game_over      = (state_q == OVER);
  assign game_won       = won_q;
  assign err            = (state_q == ERR);

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Self-checking bench for mine_game_ctrl: per-cycle vector table plus a
// hand-written asynchronous restart sequence.
module tb_mine_game_ctrl;

  logic       clka = 1'b0;
  logic       restart;
  logic       new_game;
  logic [4:0] moves;
  logic       game_over;
  logic       game_won;
  logic       err;

  mine_game_ctrl_if mif();

  mine_game_ctrl dut (
    .clka      (clka),
    .restart   (restart),
    .new_game  (new_game),
    .mif       (mif),
    .moves     (moves),
    .game_over (game_over),
    .game_won  (game_won),
    .err       (err)
  );

  always #5 clka = ~clka;

  // strobe field order: {start, load, decode, alu, display}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] ST = 5'b10000;
  localparam logic [4:0] LD = 5'b01000;
  localparam logic [4:0] DC = 5'b00100;
  localparam logic [4:0] AL = 5'b00010;
  localparam logic [4:0] DS = 5'b00001;
  // done field order: {place_done, decode_done, alu_done, display_done}
  localparam logic [3:0] D0 = 4'b0000;
  localparam logic [3:0] PD = 4'b1000;
  localparam logic [3:0] DD = 4'b0100;
  localparam logic [3:0] AD = 4'b0010;
  localparam logic [3:0] XD = 4'b0001;

  typedef struct {
    string      name;
    logic       ng;
    logic       mv;
    logic [4:0] md;
    logic [3:0] dn;
    logic       go;
    logic       wn;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_bad     = 0;

  function automatic logic [19:0] pk(logic [4:0] strb, logic rdy, logic merr,
                                     logic [4:0] d, logic [4:0] m,
                                     logic ov, logic wn, logic er);
    return {strb, rdy, merr, d, m, ov, wn, er};
  endfunction

  task automatic add(string nm, logic ng, logic mv, logic [4:0] md, logic [3:0] dn,
                     logic go, logic wn, logic [19:0] e);
    vec_t v;
    v.name = nm; v.ng = ng; v.mv = mv; v.md = md; v.dn = dn;
    v.go = go; v.wn = wn; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic ng, logic mv, logic [4:0] md, logic [3:0] dn,
                       logic go, logic wn);
    new_game         = ng;
    mif.move_valid   = mv;
    mif.move_data    = md;
    mif.place_done   = dn[3];
    mif.decode_done  = dn[2];
    mif.alu_done     = dn[1];
    mif.display_done = dn[0];
    mif.gameover     = go;
    mif.win          = wn;
  endtask

  task automatic check(string nm, logic [19:0] e);
    logic [19:0] act;
    act = {mif.start, mif.load, mif.decode, mif.alu, mif.display,
           mif.move_ready, mif.move_err, mif.data, moves, game_over, game_won, err};
    n_applied++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: actual=%05h required=%05h", nm, act, e);
    end
  endtask

  initial begin
    // ---- vector table: inputs for one cycle, outputs expected after the edge ----
    add("idle",      1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0));
    add("new_game",  1'b1, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0));
    add("place_c2",  1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0));
    add("place_c3",  1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0));
    add("place_dn",  1'b0, 1'b0, 5'd0,  PD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0));
    add("mv12",      1'b0, 1'b1, 5'd12, D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("load",      1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("dec_dn",    1'b0, 1'b0, 5'd0,  DD, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("alu_dn",    1'b0, 1'b0, 5'd0,  AD, 1'b0, 1'b0, pk(DS, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("disp_dn",   1'b0, 1'b0, 5'd0,  XD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("dup12",     1'b0, 1'b1, 5'd12, D0, 1'b0, 1'b0, pk(NO, 1'b1, 1'b1, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("bad27",     1'b0, 1'b1, 5'd27, D0, 1'b0, 1'b0, pk(NO, 1'b1, 1'b1, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("bad25",     1'b0, 1'b1, 5'd25, D0, 1'b0, 1'b0, pk(NO, 1'b1, 1'b1, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("quiet",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("mv24_ng",   1'b1, 1'b1, 5'd24, D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd24, 5'd2, 1'b0, 1'b0, 1'b0));
    add("load2",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd24, 5'd2, 1'b0, 1'b0, 1'b0));
    add("stale_ad",  1'b0, 1'b0, 5'd0,  AD, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd24, 5'd2, 1'b0, 1'b0, 1'b0));
    add("dec_dn2",   1'b0, 1'b0, 5'd0,  DD, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd24, 5'd2, 1'b0, 1'b0, 1'b0));
    add("alu_win",   1'b0, 1'b0, 5'd0,  AD, 1'b1, 1'b1, pk(DS, 1'b0, 1'b0, 5'd24, 5'd2, 1'b0, 1'b0, 1'b0));
    add("disp_over", 1'b0, 1'b0, 5'd0,  XD, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd24, 5'd2, 1'b1, 1'b1, 1'b0));
    add("over_hold", 1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd24, 5'd2, 1'b1, 1'b1, 1'b0));
    add("ng_again",  1'b1, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd24, 5'd0, 1'b0, 1'b0, 1'b0));
    add("place_dn2", 1'b0, 1'b0, 5'd0,  PD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd24, 5'd0, 1'b0, 1'b0, 1'b0));
    add("mv12_new",  1'b0, 1'b1, 5'd12, D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("load3",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++)
      add("dec_wait", 1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0));
    add("dec_tmo",   1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b1));
    add("err_hold",  1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd12, 5'd1, 1'b0, 1'b0, 1'b1));
    add("ng_err",    1'b1, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0));
    add("place_dn3", 1'b0, 1'b0, 5'd0,  PD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0));
    add("mv5",       1'b0, 1'b1, 5'd5,  D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd5,  5'd1, 1'b0, 1'b0, 1'b0));
    add("load4",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd5,  5'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++)
      add("dec_wait2", 1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0));
    add("dec_late",  1'b0, 1'b0, 5'd0,  DD, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd5,  5'd1, 1'b0, 1'b0, 1'b0));
    add("alu_dn4",   1'b0, 1'b0, 5'd0,  AD, 1'b0, 1'b0, pk(DS, 1'b0, 1'b0, 5'd5,  5'd1, 1'b0, 1'b0, 1'b0));
    add("disp_dn4",  1'b0, 1'b0, 5'd0,  XD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd5,  5'd1, 1'b0, 1'b0, 1'b0));
    add("mv6",       1'b0, 1'b1, 5'd6,  D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd6,  5'd2, 1'b0, 1'b0, 1'b0));
    add("load5",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd6,  5'd2, 1'b0, 1'b0, 1'b0));
    add("dec_dn5",   1'b0, 1'b0, 5'd0,  DD, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd6,  5'd2, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++)
      add("alu_wait", 1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd6, 5'd2, 1'b0, 1'b0, 1'b0));
    add("alu_tmo",   1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(NO, 1'b0, 1'b0, 5'd6,  5'd2, 1'b0, 1'b0, 1'b1));
    add("ng_err2",   1'b1, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(ST, 1'b0, 1'b0, 5'd6,  5'd0, 1'b0, 1'b0, 1'b0));
    add("place_dn4", 1'b0, 1'b0, 5'd0,  PD, 1'b0, 1'b0, pk(NO, 1'b1, 1'b0, 5'd6,  5'd0, 1'b0, 1'b0, 1'b0));
    add("mv7",       1'b0, 1'b1, 5'd7,  D0, 1'b0, 1'b0, pk(LD, 1'b0, 1'b0, 5'd7,  5'd1, 1'b0, 1'b0, 1'b0));
    add("load6",     1'b0, 1'b0, 5'd0,  D0, 1'b0, 1'b0, pk(DC, 1'b0, 1'b0, 5'd7,  5'd1, 1'b0, 1'b0, 1'b0));
    add("dec_dn6",   1'b0, 1'b0, 5'd0,  DD, 1'b0, 1'b0, pk(AL, 1'b0, 1'b0, 5'd7,  5'd1, 1'b0, 1'b0, 1'b0));

    // ---- reset state ----
    restart = 1'b1;
    drive(1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0);
    repeat (2) @(posedge clka);
    #1;
    check("reset", pk(NO, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clka);
    restart = 1'b0;

    // ---- table ----
    foreach (vecs[k]) begin
      @(negedge clka);
      drive(vecs[k].ng, vecs[k].mv, vecs[k].md, vecs[k].dn, vecs[k].go, vecs[k].wn);
      @(posedge clka);
      #1;
      check(vecs[k].name, vecs[k].exp);
    end

    // ---- asynchronous restart while in ALU: outputs clear before the next edge ----
    drive(1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0);
    #3;
    restart = 1'b1;
    #1;
    check("async_rst", pk(NO, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clka);
    restart = 1'b0;
    drive(1'b0, 1'b0, 5'd0, AD, 1'b0, 1'b0);
    @(posedge clka);
    #1;
    check("stale_alu_idle", pk(NO, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clka);
    drive(1'b0, 1'b0, 5'd0, D0, 1'b0, 1'b0);
    @(posedge clka);
    #1;
    check("idle_after_rst", pk(NO, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule
